// File: rtl/i2c_temp_poll_ctrl_if.sv
// Command/response bundle between the temperature poller and the I2C master.
// The poller drives the command side through the master modport; the I2C master uses slave.
interface i2c_temp_poll_ctrl_if;
    logic       m_go;
    logic       m_rw;
    logic [5:0] m_n_byte;
    logic [6:0] m_dev_add;
    logic [7:0] m_r_pointer;
    logic [7:0] m_dwr;
    logic       m_done;
    logic       m_ready;
    logic [7:0] m_drd;
    logic       m_ack_e;

    modport master (
        output m_go, m_rw, m_n_byte, m_dev_add, m_r_pointer, m_dwr,
        input  m_done, m_ready, m_drd, m_ack_e
    );

    modport slave (
        input  m_go, m_rw, m_n_byte, m_dev_add, m_r_pointer, m_dwr,
        output m_done, m_ready, m_drd, m_ack_e
    );
endinterface

// File: rtl/i2c_temp_poll_ctrl.sv
// Temp sensor poller: one config write after reset, then periodic 2-byte reads.
// Optional TEMP_ALERT_EN adds a registered over-threshold flag on temp_alert.
module i2c_temp_poll_ctrl #(
    parameter logic [6:0]  DEV_ADDR       = 7'h48,
    parameter logic [7:0]  CFG_PTR        = 8'h01,
    parameter logic [7:0]  CFG_VALUE      = 8'h60,
    parameter logic [7:0]  TEMP_PTR       = 8'h00,
    parameter logic [23:0] POLL_CYCLES    = 24'd5_000_000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000,
    parameter logic [15:0] ALERT_THRESH   = 16'h1E00
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    i2c_temp_poll_ctrl_if.master        bus,
    output logic [15:0]                 temp,
    output logic                        temp_valid,
    output logic                        busy,
    output logic                        nack_err,
    output logic                        timeout_err,
    output logic                        temp_alert
);

    typedef enum logic [2:0] {
        IDLE, CFG_GO, CFG_WAIT, POLL_WAIT, RD_GO, RD_WAIT, RESULT
    } state_t;

    state_t      state_q, state_d;
    logic        go_q, go_d;
    logic        rw_q, rw_d;
    logic [5:0]  n_byte_q, n_byte_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  dwr_q, dwr_d;
    logic        cfg_done_q, cfg_done_d;
    logic        nack_q, nack_d;
    logic [23:0] tmo_cnt_q, tmo_cnt_d;
    logic [23:0] poll_cnt_q, poll_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  msb_q, msb_d;
    logic [7:0]  lsb_q, lsb_d;
    logic [15:0] temp_q, temp_d;
    logic        temp_valid_q, temp_valid_d;
    logic        nack_err_q, nack_err_d;
    logic        timeout_err_q, timeout_err_d;
    logic        done_prev_q, ready_prev_q;

    logic done_rise, done_fall, ready_rise;
    logic in_go, in_wait, tmo_hit;
    logic start_cfg, start_rd, enter_poll, timed_out;

    assign done_rise  = bus.m_done & ~done_prev_q;
    assign done_fall  = ~bus.m_done & done_prev_q;
    assign ready_rise = bus.m_ready & ~ready_prev_q;
    assign in_go      = (state_q == CFG_GO) || (state_q == RD_GO);
    assign in_wait    = (state_q == CFG_WAIT) || (state_q == RD_WAIT);
    assign tmo_hit    = (in_go || in_wait) &&
                        (tmo_cnt_q >= TIMEOUT_CYCLES - 24'd1);

    always_comb begin
        state_d       = state_q;
        go_d          = go_q;
        rw_d          = rw_q;
        n_byte_d      = n_byte_q;
        ptr_d         = ptr_q;
        dwr_d         = dwr_q;
        cfg_done_d    = cfg_done_q;
        nack_d        = nack_q;
        tmo_cnt_d     = tmo_cnt_q;
        poll_cnt_d    = poll_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        msb_d         = msb_q;
        lsb_d         = lsb_q;
        temp_d        = temp_q;
        temp_valid_d  = 1'b0;
        nack_err_d    = nack_err_q;
        timeout_err_d = timeout_err_q;
        start_cfg     = 1'b0;
        start_rd      = 1'b0;
        enter_poll    = 1'b0;
        timed_out     = 1'b0;

        if (in_go || in_wait) tmo_cnt_d = tmo_cnt_q + 24'd1;
        // ack_e is cleared by the master at STOP, so latch it here
        if (in_wait && bus.m_ack_e) nack_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    start_cfg = ~cfg_done_q;
                    start_rd  = cfg_done_q;
                end
            end
            CFG_GO, RD_GO: begin
                if (tmo_hit) begin
                    timed_out = 1'b1;
                end else if (done_fall) begin
                    go_d    = 1'b0;
                    state_d = (state_q == CFG_GO) ? CFG_WAIT : RD_WAIT;
                end
            end
            CFG_WAIT: begin
                if (tmo_hit) begin
                    timed_out = 1'b1;
                end else if (done_rise) begin
                    cfg_done_d = ~nack_d;
                    if (nack_d) nack_err_d = 1'b1;
                    enter_poll = 1'b1;
                end
            end
            RD_WAIT: begin
                if (ready_rise && byte_cnt_q != 2'd2) begin
                    if (byte_cnt_q == 2'd0) msb_d = bus.m_drd;
                    else                    lsb_d = bus.m_drd;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
                if (tmo_hit) begin
                    timed_out = 1'b1;
                end else if (done_rise) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (!nack_q && byte_cnt_q == 2'd2) begin
                    temp_d        = {msb_q, lsb_q};
                    temp_valid_d  = 1'b1;
                    nack_err_d    = 1'b0;
                    timeout_err_d = 1'b0;
                end else begin
                    nack_err_d = 1'b1;
                end
                enter_poll = 1'b1;
            end
            POLL_WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (poll_cnt_q == 24'd0) begin
                    start_cfg = ~cfg_done_q;
                    start_rd  = cfg_done_q;
                end else begin
                    poll_cnt_d = poll_cnt_q - 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timed_out) begin
            go_d          = 1'b0;
            timeout_err_d = 1'b1;
            enter_poll    = 1'b1;
        end

        if (enter_poll) begin
            state_d    = POLL_WAIT;
            poll_cnt_d = POLL_CYCLES - 24'd1;
        end

        if (start_cfg || start_rd) begin
            go_d       = 1'b1;
            tmo_cnt_d  = 24'd0;
            nack_d     = 1'b0;
            byte_cnt_d = 2'd0;
        end

        if (start_cfg) begin
            state_d  = CFG_GO;
            rw_d     = 1'b0;
            n_byte_d = 6'd1;
            ptr_d    = CFG_PTR;
            dwr_d    = CFG_VALUE;
        end

        if (start_rd) begin
            state_d  = RD_GO;
            rw_d     = 1'b1;
            n_byte_d = 6'd2;
            ptr_d    = TEMP_PTR;
            dwr_d    = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            go_q          <= 1'b0;
            rw_q          <= 1'b0;
            n_byte_q      <= 6'd0;
            ptr_q         <= 8'h00;
            dwr_q         <= 8'h00;
            cfg_done_q    <= 1'b0;
            nack_q        <= 1'b0;
            tmo_cnt_q     <= 24'd0;
            poll_cnt_q    <= 24'd0;
            byte_cnt_q    <= 2'd0;
            msb_q         <= 8'h00;
            lsb_q         <= 8'h00;
            temp_q        <= 16'h0000;
            temp_valid_q  <= 1'b0;
            nack_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            // idle master holds done high; avoid a false rise after reset
            done_prev_q   <= 1'b1;
            ready_prev_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            go_q          <= go_d;
            rw_q          <= rw_d;
            n_byte_q      <= n_byte_d;
            ptr_q         <= ptr_d;
            dwr_q         <= dwr_d;
            cfg_done_q    <= cfg_done_d;
            nack_q        <= nack_d;
            tmo_cnt_q     <= tmo_cnt_d;
            poll_cnt_q    <= poll_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            msb_q         <= msb_d;
            lsb_q         <= lsb_d;
            temp_q        <= temp_d;
            temp_valid_q  <= temp_valid_d;
            nack_err_q    <= nack_err_d;
            timeout_err_q <= timeout_err_d;
            done_prev_q   <= bus.m_done;
            ready_prev_q  <= bus.m_ready;
        end
    end

`ifdef TEMP_ALERT_EN
    logic alert_q, alert_d;

    always_comb begin
        alert_d = alert_q;
        if (temp_valid_d) alert_d = $signed(temp_d) >= $signed(ALERT_THRESH);
    end

    always_ff @(posedge clk) begin
        if (reset) alert_q <= 1'b0;
        else       alert_q <= alert_d;
    end

    assign temp_alert = alert_q;
`else
    assign temp_alert = 1'b0 & (^ALERT_THRESH);
`endif

    assign bus.m_go        = go_q;
    assign bus.m_rw        = rw_q;
    assign bus.m_n_byte    = n_byte_q;
    assign bus.m_dev_add   = DEV_ADDR;
    assign bus.m_r_pointer = ptr_q;
    assign bus.m_dwr       = dwr_q;

    assign temp        = temp_q;
    assign temp_valid  = temp_valid_q;
    assign busy        = !(state_q == IDLE || state_q == POLL_WAIT);
    assign nack_err    = nack_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_i2c_temp_poll_ctrl.sv
// Bench for i2c_temp_poll_ctrl: behavioural I2C master model, read-vector table,
// temp scoreboard, plus timeout, enable-drop and mid-transaction reset sequences.
`timescale 1ns/1ps
module tb_i2c_temp_poll_ctrl;

    localparam logic [23:0] P = 24'd40;
    localparam logic [23:0] T = 24'd100;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] temp;
    logic        temp_valid, busy, nack_err, timeout_err, temp_alert;

    i2c_temp_poll_ctrl_if bus ();

    i2c_temp_poll_ctrl #(
        .POLL_CYCLES(P),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .bus(bus),
        .temp(temp),
        .temp_valid(temp_valid),
        .busy(busy),
        .nack_err(nack_err),
        .timeout_err(timeout_err),
        .temp_alert(temp_alert)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_alert(input logic [15:0] t);
`ifdef TEMP_ALERT_EN
        return $signed(t) >= $signed(16'h1E00);
`else
        return 1'b0 & t[0];
`endif
    endfunction

    // master model: 0 = ack, 1 = nack during read, 2 = ignore go
    logic [7:0] mb0, mb1;
    int         mmode;
    int         txn_cnt = 0;
    logic       in_txn = 1'b0;
    logic       l_rw;
    logic [5:0] l_n;
    logic [7:0] l_ptr, l_dwr;
    logic [6:0] l_dev;
    int         start_cyc = 0, done_cyc = 0;
    logic [15:0] exp_q[$];

    initial begin
        bus.m_done  = 1'b1;
        bus.m_ready = 1'b0;
        bus.m_drd   = 8'h00;
        bus.m_ack_e = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.m_go === 1'b1 && mmode != 2 && !reset) begin
                in_txn    = 1'b1;
                start_cyc = cyc;
                l_rw      = bus.m_rw;
                l_n       = bus.m_n_byte;
                l_ptr     = bus.m_r_pointer;
                l_dwr     = bus.m_dwr;
                l_dev     = bus.m_dev_add;
                bus.m_done = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                if (l_rw) begin
                    if (mmode == 0) exp_q.push_back({mb0, mb1});
                    for (int i = 0; i < int'(l_n); i++) begin
                        bus.m_drd   = (i == 0) ? mb0 : mb1;
                        bus.m_ready = 1'b1;
                        if (mmode == 1 && i == 1) bus.m_ack_e = 1'b1;
                        @(posedge clk);
                        #1;
                        bus.m_ready = 1'b0;
                        bus.m_ack_e = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                bus.m_done = 1'b1;
                done_cyc   = cyc;
                txn_cnt++;
                in_txn = 1'b0;
            end
        end
    end

    int valid_cnt = 0;
    int valid_cyc = 0;

    always @(negedge clk) begin
        if (temp_valid === 1'b1) begin
            valid_cnt++;
            valid_cyc = cyc;
            chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("sb_temp", temp, exp_q.pop_front());
        end
    end

    int go_run = 0;
    int last_go_run = 0;

    always @(negedge clk) begin
        if (bus.m_go === 1'b1) go_run++;
        else if (go_run != 0) begin
            last_go_run = go_run;
            go_run = 0;
        end
    end

    task automatic wait_cnt(input int target, input int budget, input string name);
        int k = 0;
        while (txn_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(txn_cnt >= target), 1);
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        bit          nack;
        logic [15:0] exp_temp;
        logic        exp_nack;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int base, vbase, pd, k;
        vecs[0] = '{8'h19, 8'h80, 1'b0, 16'h1980, 1'b0};
        vecs[1] = '{8'h1D, 8'hFF, 1'b0, 16'h1DFF, 1'b0};
        vecs[2] = '{8'hAA, 8'h55, 1'b1, 16'h1DFF, 1'b1};
        vecs[3] = '{8'h1E, 8'h00, 1'b0, 16'h1E00, 1'b0};
        vecs[4] = '{8'hFF, 8'hF0, 1'b0, 16'hFFF0, 1'b0};

        reset = 1'b1;
        enable = 1'b0;
        mmode = 0;
        mb0 = 8'h00;
        mb1 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_go", bus.m_go, 0);
        chk("rst_busy", busy, 0);
        chk("rst_temp", temp, 0);
        chk("rst_valid", temp_valid, 0);
        chk("rst_nack", nack_err, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_alert", temp_alert, 0);
        chk("rst_dev", bus.m_dev_add, 7'h48);

        reset = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        wait_cnt(1, 200, "cfg_txn");
        chk("cfg_rw", l_rw, 0);
        chk("cfg_n", l_n, 1);
        chk("cfg_ptr", l_ptr, 8'h01);
        chk("cfg_dwr", l_dwr, 8'h60);
        chk("cfg_dev", l_dev, 7'h48);

        for (int i = 0; i < 5; i++) begin
            mb0   = vecs[i].b0;
            mb1   = vecs[i].b1;
            mmode = vecs[i].nack ? 1 : 0;
            base  = txn_cnt;
            vbase = valid_cnt;
            pd    = done_cyc;
            wait_cnt(base + 1, 300, "rd_txn");
            repeat (4) @(negedge clk);
            chk("vec_temp", temp, vecs[i].exp_temp);
            chk("vec_nack", nack_err, vecs[i].exp_nack);
            chk("vec_valid", valid_cnt - vbase, vecs[i].nack ? 0 : 1);
            chk("vec_busy", busy, 0);
            chk("vec_tmo", timeout_err, 0);
            chk("vec_alert", temp_alert, exp_alert(vecs[i].exp_temp));
            if (i == 0) begin
                chk("rd_rw", l_rw, 1);
                chk("rd_n", l_n, 2);
                chk("rd_ptr", l_ptr, 8'h00);
                chk("rd_latency", valid_cyc - done_cyc, 2);
            end else begin
                chk("poll_gap", start_cyc - pd, int'(P) + 2);
            end
        end

        // master ignores go: go must be held, then dropped at timeout
        mmode = 2;
        k = 0;
        while (bus.m_go !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("to_go_seen", bus.m_go, 1);
        repeat (50) @(negedge clk);
        chk("to_go_held", bus.m_go, 1);
        chk("to_busy", busy, 1);
        k = 0;
        while (timeout_err !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("to_flag", timeout_err, 1);
        chk("to_go_drop", bus.m_go, 0);
        chk("to_temp", temp, 16'hFFF0);
        @(negedge clk);
        chk("to_go_len", last_go_run, int'(T));
        chk("to_idle", busy, 0);

        mmode = 0;
        mb0 = 8'h12;
        mb1 = 8'h34;
        base = txn_cnt;
        wait_cnt(base + 1, 300, "rec_txn");
        repeat (4) @(negedge clk);
        chk("rec_temp", temp, 16'h1234);
        chk("rec_tmo", timeout_err, 0);
        chk("rec_nack", nack_err, 0);

        // drop enable mid-read
        mb0 = 8'h2B;
        mb1 = 8'h11;
        base = txn_cnt;
        k = 0;
        while (in_txn !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("en_started", in_txn, 1);
        repeat (3) @(negedge clk);
        chk("en_busy_mid", busy, 1);
        enable = 1'b0;
        wait_cnt(base + 1, 100, "en_txn");
        repeat (4) @(negedge clk);
        chk("en_temp", temp, 16'h2B11);
        chk("en_busy", busy, 0);
        repeat (60) @(negedge clk);
        chk("en_no_more", txn_cnt, base + 1);
        chk("en_idle", busy, 0);

        // reset while go is asserted
        mmode = 2;
        enable = 1'b1;
        k = 0;
        while (bus.m_go !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("mr_go_seen", bus.m_go, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_go", bus.m_go, 0);
        chk("mr_busy", busy, 0);
        chk("mr_temp", temp, 0);
        reset = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);

        chk("sb_empty", exp_q.size(), 0);
        chk("valid_total", valid_cnt, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
